// File: rtl/program_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : program_sequencer_pkg
//  Description : Shared definitions for the program sequencer: default
//                parameter values and the next-address select encoding used
//                by the priority decode in the top level.
//  Revision    : 1.0 - initial release
// ============================================================================
package program_sequencer_pkg;

    localparam int DEF_ADDR_W      = 8;
    localparam int DEF_OFF_W       = 2;
    localparam int DEF_STACK_DEPTH = 4;
    localparam int DEF_RESET_ADDR  = 0;

    // Source of the next program address.
    typedef enum logic [2:0] {
        SEL_INC  = 3'd0,   // ADDR + 1
        SEL_JREL = 3'd1,   // ADDR + 1 + sign-extended offset
        SEL_JABS = 3'd2,   // absolute jump target
        SEL_CALL = 3'd3,   // call target (return address is pushed)
        SEL_RET  = 3'd4    // top of the return stack
    } next_sel_e;

endpackage : program_sequencer_pkg
`default_nettype wire

// File: rtl/program_sequencer_return_stack.sv
`default_nettype none
// ============================================================================
//  Module      : return_stack
//  Description : LIFO of return addresses with an occupancy counter. A push
//                while full and a pop while empty are silently ignored; the
//                caller is responsible for flagging those conditions.
//  Ports       : clk, rst_n      - falling-edge clock, async active-low reset
//                push, pop       - stack operations (push has precedence)
//                push_data       - address written on push
//                top_data        - current top entry (0 when empty)
//                sp              - number of occupied entries
//                full, empty     - sp == STACK_DEPTH / sp == 0
//  Revision    : 1.0 - initial release
// ============================================================================
module return_stack #(
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               push,
    input  logic                               pop,
    input  logic [ADDR_W-1:0]                  push_data,
    output logic [ADDR_W-1:0]                  top_data,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   sp,
    output logic                               full,
    output logic                               empty
);

    localparam int c_sp_w  = $clog2(STACK_DEPTH + 1);
    localparam int c_idx_w = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [ADDR_W-1:0]  r_mem [STACK_DEPTH];
    logic [c_sp_w-1:0]  r_sp;
    logic [c_idx_w-1:0] w_wr_idx;
    logic [c_idx_w-1:0] w_top_idx;

    assign full      = (r_sp == c_sp_w'(STACK_DEPTH));
    assign empty     = (r_sp == '0);
    assign sp        = r_sp;
    // Index truncation is safe: writes only happen below STACK_DEPTH and
    // reads only happen when at least one entry is occupied.
    assign w_wr_idx  = c_idx_w'(r_sp);
    assign w_top_idx = c_idx_w'(r_sp - c_sp_w'(1));
    assign top_data  = empty ? '0 : r_mem[w_top_idx];

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sp <= '0;
        end else if (push && !full) begin
            r_sp <= r_sp + c_sp_w'(1);
        end else if (pop && !empty) begin
            r_sp <= r_sp - c_sp_w'(1);
        end
    end

    // Storage is left uncleared on reset; sp == 0 hides stale entries.
    always_ff @(negedge clk) begin
        if (push && !full) begin
            r_mem[w_wr_idx] <= push_data;
        end
    end

endmodule : return_stack
`default_nettype wire

// File: rtl/program_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : program_sequencer
//  Description : Program-address sequencer with increment, relative/absolute
//                jump, call and return. Commands are evaluated on the falling
//                clock edge when en=1, priority RET > CALL > JMP > increment,
//                each completing in a single edge.
//  Ports       : clk, rst_n      - falling-edge clock, async active-low reset
//                en              - advance enable (0 = hold everything)
//                jmp, jmp_abs    - jump request, absolute/relative select
//                jmp_offset      - signed offset, relative to addr+1
//                jmp_target      - destination for absolute jump and call
//                call, ret       - subroutine call / return
//                addr, sp        - current address, stack occupancy
//                stack_full/empty- decoded from sp
//                ovf, unf        - sticky overflow / underflow flags
//  Revision    : 1.0 - initial release
// ============================================================================
module program_sequencer
    import program_sequencer_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int OFF_W       = DEF_OFF_W,
    parameter int STACK_DEPTH = DEF_STACK_DEPTH,
    parameter int RESET_ADDR  = DEF_RESET_ADDR
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               en,
    input  logic                               jmp,
    input  logic                               jmp_abs,
    input  logic [OFF_W-1:0]                   jmp_offset,
    input  logic [ADDR_W-1:0]                  jmp_target,
    input  logic                               call,
    input  logic                               ret,
    output logic [ADDR_W-1:0]                  addr,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   sp,
    output logic                               stack_full,
    output logic                               stack_empty,
    output logic                               ovf,
    output logic                               unf
);

    logic [ADDR_W-1:0] r_addr;
    logic              r_ovf;
    logic              r_unf;

    next_sel_e         w_sel;
    logic              w_push;
    logic              w_pop;
    logic              w_set_ovf;
    logic              w_set_unf;
    logic [ADDR_W-1:0] w_top;
    logic [ADDR_W-1:0] w_off_ext;
    logic [ADDR_W-1:0] w_inc;
    logic [ADDR_W-1:0] w_rel;
    logic [ADDR_W-1:0] w_next_addr;

    // ------------------------------------------------------------------
    // Return stack
    // ------------------------------------------------------------------
    return_stack #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_return_stack (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (w_inc),
        .top_data  (w_top),
        .sp        (sp),
        .full      (stack_full),
        .empty     (stack_empty)
    );

    // ------------------------------------------------------------------
    // Offset sign extension (a zero-width pad is illegal, so split cases)
    // ------------------------------------------------------------------
    generate
        if (OFF_W < ADDR_W) begin : g_sext_pad
            assign w_off_ext = {{(ADDR_W-OFF_W){jmp_offset[OFF_W-1]}}, jmp_offset};
        end else begin : g_sext_full
            assign w_off_ext = jmp_offset;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Priority decode. A CALL on a full stack or a RET on an empty stack
    // degrades to a plain increment and raises the matching sticky flag.
    // Stack side effects are gated by en so a stall leaves the stack alone.
    // ------------------------------------------------------------------
    always_comb begin
        w_sel     = SEL_INC;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_set_ovf = 1'b0;
        w_set_unf = 1'b0;
        if (ret) begin
            if (!stack_empty) begin
                w_sel = SEL_RET;
                w_pop = en;
            end else begin
                w_set_unf = en;
            end
        end else if (call) begin
            if (!stack_full) begin
                w_sel  = SEL_CALL;
                w_push = en;
            end else begin
                w_set_ovf = en;
            end
        end else if (jmp) begin
            w_sel = jmp_abs ? SEL_JABS : SEL_JREL;
        end
    end

    // ------------------------------------------------------------------
    // Next-address datapath; all arithmetic wraps at 2^ADDR_W.
    // ------------------------------------------------------------------
    assign w_inc = r_addr + ADDR_W'(1);
    assign w_rel = w_inc + w_off_ext;

    always_comb begin
        w_next_addr = w_inc;
        case (w_sel)
            SEL_INC:  w_next_addr = w_inc;
            SEL_JREL: w_next_addr = w_rel;
            SEL_JABS: w_next_addr = jmp_target;
            SEL_CALL: w_next_addr = jmp_target;
            SEL_RET:  w_next_addr = w_top;
            default:  w_next_addr = w_inc;
        endcase
    end

    // ------------------------------------------------------------------
    // Address and flag registers
    // ------------------------------------------------------------------
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr <= ADDR_W'(RESET_ADDR);
            r_ovf  <= 1'b0;
            r_unf  <= 1'b0;
        end else if (en) begin
            r_addr <= w_next_addr;
            if (w_set_ovf) begin
                r_ovf <= 1'b1;
            end
            if (w_set_unf) begin
                r_unf <= 1'b1;
            end
        end
    end

    assign addr = r_addr;
    assign ovf  = r_ovf;
    assign unf  = r_unf;

endmodule : program_sequencer
`default_nettype wire

// File: tb/tb_program_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_program_sequencer
//  Description : Self-checking bench for program_sequencer. Directed steps for
//                the documented scenarios followed by random commands, all
//                compared against a queue-based behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_program_sequencer;

    localparam int ADDR_W = 8;
    localparam int OFF_W  = 2;
    localparam int DEPTH  = 4;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       jmp;
    logic       jmp_abs;
    logic [1:0] jmp_offset;
    logic [7:0] jmp_target;
    logic       call;
    logic       ret;
    logic [7:0] addr;
    logic [2:0] sp;
    logic       stack_full;
    logic       stack_empty;
    logic       ovf;
    logic       unf;

    program_sequencer #(
        .ADDR_W      (ADDR_W),
        .OFF_W       (OFF_W),
        .STACK_DEPTH (DEPTH),
        .RESET_ADDR  (0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .jmp         (jmp),
        .jmp_abs     (jmp_abs),
        .jmp_offset  (jmp_offset),
        .jmp_target  (jmp_target),
        .call        (call),
        .ret         (ret),
        .addr        (addr),
        .sp          (sp),
        .stack_full  (stack_full),
        .stack_empty (stack_empty),
        .ovf         (ovf),
        .unf         (unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Behavioural reference
    int m_addr;
    int m_stack[$];
    bit m_ovf;
    bit m_unf;

    int exp38[4] = '{6, 7, 4, 5};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, "_addr"},  32'(addr),        32'(m_addr));
        chk({tag, "_sp"},    32'(sp),          32'(m_stack.size()));
        chk({tag, "_full"},  32'(stack_full),  32'(m_stack.size() == DEPTH));
        chk({tag, "_empty"}, 32'(stack_empty), 32'(m_stack.size() == 0));
        chk({tag, "_ovf"},   32'(ovf),         32'(m_ovf));
        chk({tag, "_unf"},   32'(unf),         32'(m_unf));
    endtask

    task automatic model_reset();
        m_addr = 0;
        m_stack.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    // One falling-edge evaluation of the command rules on the current inputs.
    task automatic model_step();
        int soff;
        if (!en) return;
        if (ret) begin
            if (m_stack.size() > 0) begin
                m_addr = m_stack.pop_back();
            end else begin
                m_unf  = 1'b1;
                m_addr = (m_addr + 1) % 256;
            end
        end else if (call) begin
            if (m_stack.size() < DEPTH) begin
                m_stack.push_back((m_addr + 1) % 256);
                m_addr = int'(jmp_target);
            end else begin
                m_ovf  = 1'b1;
                m_addr = (m_addr + 1) % 256;
            end
        end else if (jmp) begin
            if (jmp_abs) begin
                m_addr = int'(jmp_target);
            end else begin
                soff   = (jmp_offset >= 2) ? int'(jmp_offset) - 4 : int'(jmp_offset);
                m_addr = (m_addr + 1 + soff) & 255;
            end
        end else begin
            m_addr = (m_addr + 1) % 256;
        end
    endtask

    // Drive one command just after a rising edge, let the falling edge act,
    // then compare on the next rising edge.
    task automatic cyc(input bit e, input bit j, input bit a, input logic [1:0] o,
                       input logic [7:0] t, input bit c, input bit r, input string tag);
        en         = e;
        jmp        = j;
        jmp_abs    = a;
        jmp_offset = o;
        jmp_target = t;
        call       = c;
        ret        = r;
        @(negedge clk);
        if (rst_n) model_step();
        else       model_reset();
        @(posedge clk);
        chk_all(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        en = 1'b0; jmp = 1'b0; jmp_abs = 1'b0; jmp_offset = '0;
        jmp_target = '0; call = 1'b0; ret = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        chk_all("reset");
        rst_n = 1'b1;

        // Increment and stall
        for (int k = 1; k <= 3; k++) begin
            cyc(1, 0, 0, 2'b00, 8'h00, 0, 0, "inc");
            chk("inc_lit", 32'(addr), 32'(k));
        end
        for (int k = 0; k < 2; k++) begin
            cyc(0, 1, 1, 2'b00, 8'hAA, 1, 0, "stall");
            chk("stall_lit", 32'(addr), 32'd3);
        end

        // Relative jumps from 5, then absolute to 0x80
        for (int k = 0; k < 4; k++) begin
            cyc(1, 1, 1, 2'b00, 8'h05, 0, 0, "set5");
            cyc(1, 1, 0, 2'(k), 8'h00, 0, 0, "jrel");
            chk("jrel_lit", 32'(addr), 32'(exp38[k]));
        end
        cyc(1, 1, 1, 2'b00, 8'h80, 0, 0, "jabs");
        chk("jabs_lit", 32'(addr), 32'h80);

        // Wrap-around
        cyc(1, 1, 1, 2'b00, 8'hFF, 0, 0, "setff");
        cyc(1, 0, 0, 2'b00, 8'h00, 0, 0, "wrap_inc");
        chk("wrap_inc_lit", 32'(addr), 32'h00);
        cyc(1, 1, 0, 2'b10, 8'h00, 0, 0, "wrap_rel");
        chk("wrap_rel_lit", 32'(addr), 32'hFF);
        chk("wrap_flags", 32'({ovf, unf}), 32'd0);

        // Call and return, RET wins over CALL+JMP
        cyc(1, 1, 1, 2'b00, 8'h10, 0, 0, "set10");
        cyc(1, 0, 0, 2'b00, 8'h40, 1, 0, "call1");
        chk("call1_lit", 32'({addr, 5'd0, sp}), 32'({8'h40, 5'd0, 3'd1}));
        cyc(1, 1, 1, 2'b01, 8'h33, 1, 1, "prio");
        chk("prio_lit", 32'({addr, 5'd0, sp}), 32'({8'h11, 5'd0, 3'd0}));

        // Overflow / underflow
        cyc(1, 1, 1, 2'b00, 8'h00, 0, 0, "set00");
        for (int k = 0; k < 4; k++) cyc(1, 0, 0, 2'b00, 8'h20, 1, 0, "fill");
        chk("full_lit", 32'({sp, stack_full}), 32'({3'd4, 1'b1}));
        cyc(1, 0, 0, 2'b00, 8'h20, 1, 0, "ovf");
        chk("ovf_lit", 32'({addr, sp, ovf}), 32'({8'h21, 3'd4, 1'b1}));
        for (int k = 0; k < 4; k++) cyc(1, 0, 0, 2'b00, 8'h00, 0, 1, "drain");
        chk("drain_lit", 32'(addr), 32'h01);
        cyc(1, 0, 0, 2'b00, 8'h00, 0, 1, "unf");
        chk("unf_lit", 32'({addr, ovf, unf}), 32'({8'h02, 1'b1, 1'b1}));
        cyc(1, 1, 0, 2'b01, 8'h00, 0, 0, "sticky");

        // Asynchronous reset between edges with SP=2, OVF=1
        cyc(1, 0, 0, 2'b00, 8'h30, 1, 0, "pre_rst1");
        cyc(1, 0, 0, 2'b00, 8'h50, 1, 0, "pre_rst2");
        chk("pre_rst_lit", 32'({sp, ovf}), 32'({3'd2, 1'b1}));
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk_all("async_rst");
        chk("async_rst_lit", 32'({addr, sp, ovf, unf}), 32'd0);
        @(posedge clk);

        // Reset held through a CALL edge must win
        cyc(1, 0, 0, 2'b00, 8'h77, 1, 0, "rst_call");
        rst_n = 1'b1;
        cyc(1, 0, 0, 2'b00, 8'h00, 0, 0, "post_rst");

        // Random commands
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 9) != 0,
                1'($urandom), 1'($urandom), 2'($urandom), 8'($urandom),
                $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, "rand");
            if (i == 200) begin
                #2;
                rst_n = 1'b0;
                model_reset();
                #1;
                chk_all("rand_rst");
                @(posedge clk);
                rst_n = 1'b1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_program_sequencer
`default_nettype wire
